// File: rtl/vga_timing_gen_param.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_param
// Brief    : Parametrised VGA timing generator. Issues pixel requests to an
//            upstream source and re-aligns sync/de/rgb to its read latency.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen_param #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CLK_DIV  = 4,
    parameter int PIX_LAT  = 2,
    parameter int RGB_W    = 12,
    parameter int CW       = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [RGB_W-1:0] solid_rgb,
    input  logic [RGB_W-1:0] pix_in,
    output logic             pix_req,
    output logic [CW-1:0]    pix_x,
    output logic [CW-1:0]    pix_y,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_start,
    output logic             line_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_BAR_W   = H_ACTIVE / 8;
    localparam int c_CH      = RGB_W / 3;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [CW-1:0] c_H_LAST   = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST   = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] c_BAR_LAST = CW'(c_BAR_W - 1);
    localparam logic          c_SYNC_ON  = (SYNC_POL != 0);

    // Pipeline word: {hs, vs, de, first_frame, first_line, sel[1:0], bar_rgb}
    localparam int c_PW   = RGB_W + 7;
    localparam int c_B_HS = RGB_W + 6;
    localparam int c_B_VS = RGB_W + 5;
    localparam int c_B_DE = RGB_W + 4;
    localparam int c_B_FF = RGB_W + 3;
    localparam int c_B_FL = RGB_W + 2;

    localparam logic [1:0] c_SEL_EXT   = 2'd0;
    localparam logic [1:0] c_SEL_BAR   = 2'd1;
    localparam logic [1:0] c_SEL_SOLID = 2'd2;

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               w_tick;

    logic [CW-1:0]      r_h, r_v, w_h_nxt, w_v_nxt;
    logic [CW-1:0]      r_bar_cnt, w_bar_cnt_nxt;
    logic [2:0]         r_bar_idx, w_bar_idx_nxt;
    logic [1:0]         r_mode, w_mode;
    logic               w_first;

    logic               w_hs_a, w_vs_a, w_de_a, w_line0;
    logic [1:0]         w_sel;
    logic [RGB_W-1:0]   w_bar_rgb;
    logic [c_PW-1:0]    w_req;
    logic [c_PW-1:0]    r_pipe [PIX_LAT];
    logic [c_PW-1:0]    w_out;
    logic [RGB_W-1:0]   w_pix_rgb;

    logic               r_pix_req;
    logic [CW-1:0]      r_pix_x, r_pix_y;
    logic               r_h_sync, r_v_sync, r_de;
    logic [RGB_W-1:0]   r_rgb;
    logic               r_frame_start, r_line_start;

    assign w_tick = !rst && (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Next request position; everything at the request stage is decoded
    // from the value the counters are about to take.
    always_comb begin
        w_h_nxt = r_h + 1'b1;
        w_v_nxt = r_v;
        if (r_h == c_H_LAST) begin
            w_h_nxt = '0;
            w_v_nxt = (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
        end
    end

    always_comb begin
        w_bar_cnt_nxt = r_bar_cnt + 1'b1;
        w_bar_idx_nxt = r_bar_idx;
        if (w_h_nxt == '0) begin
            w_bar_cnt_nxt = '0;
            w_bar_idx_nxt = '0;
        end else if (r_bar_cnt == c_BAR_LAST) begin
            w_bar_cnt_nxt = '0;
            w_bar_idx_nxt = r_bar_idx + 1'b1;
        end
    end

    assign w_first = (w_h_nxt == '0) && (w_v_nxt == '0);
    assign w_mode  = w_first ? mode : r_mode;

    always_comb begin
        w_hs_a  = (w_h_nxt >= c_HS_BEG) && (w_h_nxt < c_HS_END);
        w_vs_a  = (w_v_nxt >= c_VS_BEG) && (w_v_nxt < c_VS_END);
        w_de_a  = (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);
        w_line0 = (w_h_nxt == '0) && (w_v_nxt < c_V_ACT);
        w_sel   = (w_mode == 2'd0) ? c_SEL_EXT :
                  (w_mode == 2'd1) ? c_SEL_BAR : c_SEL_SOLID;
        // Bar order white..black maps idx bits to (R,G,B) = ~(idx1, idx2, idx0)
        w_bar_rgb = {{c_CH{~w_bar_idx_nxt[1]}},
                     {c_CH{~w_bar_idx_nxt[2]}},
                     {c_CH{~w_bar_idx_nxt[0]}}};
        w_req   = {w_hs_a, w_vs_a, w_de_a, w_first, w_line0, w_sel, w_bar_rgb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h       <= c_H_LAST;
            r_v       <= c_V_LAST;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
            r_mode    <= '0;
            r_pix_req <= 1'b0;
            r_pix_x   <= '0;
            r_pix_y   <= '0;
        end else if (w_tick) begin
            r_h       <= w_h_nxt;
            r_v       <= w_v_nxt;
            r_bar_cnt <= w_bar_cnt_nxt;
            r_bar_idx <= w_bar_idx_nxt;
            r_mode    <= w_mode;
            r_pix_req <= w_de_a;
            r_pix_x   <= w_h_nxt;
            r_pix_y   <= w_v_nxt;
        end
    end

    // Stage 0 is registered together with the request; the output stage
    // loads from the last stage so request-to-pin latency is PIX_LAT ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIX_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (w_tick) begin
            r_pipe[0] <= w_req;
            for (int i = 1; i < PIX_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_out = r_pipe[PIX_LAT-1];

    always_comb begin
        w_pix_rgb = '0;
        if (w_out[c_B_DE]) begin
            case (w_out[RGB_W+1:RGB_W])
                c_SEL_EXT: w_pix_rgb = pix_in;
                c_SEL_BAR: w_pix_rgb = w_out[RGB_W-1:0];
                default:   w_pix_rgb = solid_rgb;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_sync      <= ~c_SYNC_ON;
            r_v_sync      <= ~c_SYNC_ON;
            r_de          <= 1'b0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            if (w_tick) begin
                r_h_sync      <= w_out[c_B_HS] ? c_SYNC_ON : ~c_SYNC_ON;
                r_v_sync      <= w_out[c_B_VS] ? c_SYNC_ON : ~c_SYNC_ON;
                r_de          <= w_out[c_B_DE];
                r_rgb         <= w_pix_rgb;
                r_frame_start <= w_out[c_B_FF];
                r_line_start  <= w_out[c_B_FL];
            end
        end
    end

    assign pix_req     = r_pix_req;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign h_sync      = r_h_sync;
    assign v_sync      = r_v_sync;
    assign de          = r_de;
    assign rgb         = r_rgb;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

endmodule
`default_nettype wire
